vec_sequencer: RTL and testbench
================================

# vec_sequencer

Synthesizable, parametrised test-vector player for the ALU system datapath. Holds a programmable table of control words with expected responses, drives the control word onto the datapath control bus one vector at a time, samples the datapath response after a programmable settle time, and counts mismatches. It replaces bench-only vector application with a reusable on-chip block that can run from simulation or hardware.

## Interface
Parameters:
- VEC_W, 42: control-word width (one vector drives the full datapath control bus).
- RESP_W, 8: width of the sampled response and expected value.
- DEPTH, 16: number of table entries; power of two, minimum 2.
- AW, $clog2(DEPTH): table index width.
- SETTLE, 1: cycles a vector is held before its response is sampled; minimum 1.

Ports:
- Clock  in  1  single clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- Load_En  in  1  write one table entry this cycle; ignored while Busy.
- Load_Addr  in  AW  entry index to write.
- Load_Vec  in  VEC_W  control word for the entry.
- Load_Exp  in  RESP_W  expected response for the entry.
- Load_Mask  in  RESP_W  compare mask, 1 = bit compared (present only with VSEQ_MASK_EN).
- Num_Vec  in  AW+1  vectors to run, sampled on Start; values above DEPTH clamp to DEPTH.
- Start  in  1  one-cycle pulse; begins a run from entry 0; ignored while Busy.
- Abort  in  1  ends a run early.
- Resp_In  in  RESP_W  datapath response (e.g. ALU output).
- Vec_Out  out  VEC_W  registered control word to the datapath.
- Vec_Valid  out  1  Vec_Out holds a live vector.
- Busy  out  1  run in progress.
- Done  out  1  run finished normally; held until next Start.
- VectorNum  out  AW+1  index of current vector; after run, count of vectors executed.
- Errors  out  AW+1  mismatch count, saturating at all-ones.
- First_Err  out  AW  index of first mismatching vector; valid when Errors ≠ 0.

## Operation
- Reset values: Vec_Out 0, Vec_Valid 0, Busy 0, Done 0, VectorNum 0, Errors 0, First_Err 0, state IDLE. Table contents not reset.
- FSM states IDLE, APPLY, CHECK, DONE.
- IDLE: Load_En writes table[Load_Addr] on the clock edge. Start with Num_Vec ≠ 0 → APPLY, clears Errors, First_Err, VectorNum, Done. Start with Num_Vec = 0 → DONE directly, Errors 0.
- APPLY: Vec_Out = table[VectorNum].vec, Vec_Valid 1, settle counter runs SETTLE cycles → CHECK.
- CHECK: compare Resp_In against expected (masked if enabled); mismatch increments Errors (saturating) and sets First_Err if Errors was 0. VectorNum increments. If VectorNum+1 = run length → DONE, else → APPLY with next entry. Vec_Out remains valid during CHECK.
- DONE: Vec_Out 0, Vec_Valid 0, Busy 0, Done 1; returns to IDLE behaviour (loads, Start accepted).
- Abort in APPLY/CHECK: next cycle IDLE, Vec_Out 0, Vec_Valid 0, Done 0; Errors/VectorNum/First_Err keep current values; the vector in CHECK that cycle is not compared.
- Simultaneous Start and Abort in IDLE: Abort wins, nothing starts. Load_En and Start same cycle in IDLE: write happens, run starts; entry is readable by the run.
- Busy = state is APPLY or CHECK.

## Timing
- Start at edge N → Vec_Out valid after edge N+1.
- Each vector occupies SETTLE+1 cycles; Resp_In sampled at the CHECK edge, i.e. SETTLE+1 edges after Vec_Out changed.
- Run of K vectors: Done rises K·(SETTLE+1)+1 edges after Start.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous), no partial counts retained.

## Configuration
- VSEQ_MASK_EN defined: per-entry Load_Mask stored; only mask-1 bits compared; mask 0 on every bit forces a pass.
- Not defined: Load_Mask port and mask storage absent; full RESP_W equality compare.

## Test plan
- Reset mid-run: load 4 entries, Start, assert Reset low at vector 2 → all outputs 0, Busy 0, Done 0.
- Pass run: 4 entries, Resp_In driven to match expectations, Num_Vec=4, SETTLE=1 → Done at edge 9 after Start, Errors 0, VectorNum 4.
- Fail run: entries 1 and 3 expect 8'h55, Resp_In 8'hAA → Errors 2, First_Err 1.
- Boundaries: Num_Vec=0 → Done next edge, Errors 0; Num_Vec=DEPTH+5 → exactly DEPTH vectors run, VectorNum = DEPTH.
- Abort during vector 2 of 4 → IDLE next cycle, Vec_Valid 0, Done 0, VectorNum 2; Start ignored while Busy, Load_En while Busy leaves table unchanged.
- With VSEQ_MASK_EN: expected 8'hF0, mask 8'hF0, Resp_In 8'hF7 → pass; mask 8'hFF → Errors 1.

Source files
------------

// File: rtl/vec_sequencer.sv
// vec_sequencer: on-chip test-vector player for the ALU datapath.
//
// Holds a table of control words with their expected responses. On Start it
// plays entries 0..run_len-1 onto vec_out one at a time. Each vector is held
// for SETTLE cycles and then checked for one cycle. Resp_in is sampled on the
// check edge, and every mismatch is counted.
//
// Optional feature: define VSEQ_MASK_EN to add a per-entry compare mask
// (load_mask port). When it is undefined, the full RESP_W bits are compared.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   load_en         write table[load_addr] = {load_vec, load_exp[, load_mask]}
//                   (ignored while busy)
//   num_vec         run length, sampled on start; clamped to DEPTH
//   start, abort    start a run / end a run early (abort wins over start)
//   resp_in         datapath response
//   vec_out         registered control word to the datapath
//   vec_valid       vec_out holds a live vector
//   busy, done      run in progress / run finished normally
//   vector_num      current vector index; after a run, the count executed
//   errors          saturating mismatch count
//   first_err       index of the first mismatching vector
module vec_sequencer #(
  parameter int VEC_W  = 42,
  parameter int RESP_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [VEC_W-1:0]  load_vec,
  input  logic [RESP_W-1:0] load_exp,
`ifdef VSEQ_MASK_EN
  input  logic [RESP_W-1:0] load_mask,
`endif
  input  logic [AW:0]       num_vec,
  input  logic              start,
  input  logic              abort,
  input  logic [RESP_W-1:0] resp_in,
  output logic [VEC_W-1:0]  vec_out,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       vector_num,
  output logic [AW:0]       errors,
  output logic [AW-1:0]     first_err
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt, cnt_n;
  logic [AW:0]       run_len, run_len_n;
  logic [VEC_W-1:0]  vec_n;
  logic              valid_n;
  logic [AW:0]       vnum_n;
  logic [AW:0]       err_n;
  logic [AW-1:0]     ferr_n;
  logic              tbl_we;
  logic [AW:0]       nxt;
  logic [AW-1:0]     cur_idx;
  logic [AW-1:0]     nxt_idx;
  logic              mism;

  logic [VEC_W-1:0]  tbl_vec  [DEPTH];
  logic [RESP_W-1:0] tbl_exp  [DEPTH];
`ifdef VSEQ_MASK_EN
  logic [RESP_W-1:0] tbl_mask [DEPTH];
`endif

  // The table has no reset. Its contents survive a reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_vec[load_addr] <= load_vec;
      tbl_exp[load_addr] <= load_exp;
`ifdef VSEQ_MASK_EN
      tbl_mask[load_addr] <= load_mask;
`endif
    end
  end

  assign cur_idx = vector_num[AW-1:0];
  assign nxt     = vector_num + 1'b1;
  assign nxt_idx = nxt[AW-1:0];

`ifdef VSEQ_MASK_EN
  assign mism = |((resp_in ^ tbl_exp[cur_idx]) & tbl_mask[cur_idx]);
`else
  assign mism = (resp_in != tbl_exp[cur_idx]);
`endif

  assign busy = (state == S_APPLY) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_len_n = run_len;
    vec_n     = vec_out;
    valid_n   = vec_valid;
    vnum_n    = vector_num;
    err_n     = errors;
    ferr_n    = first_err;
    tbl_we    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        tbl_we = load_en;
        if (!abort && start) begin
          err_n  = '0;
          ferr_n = '0;
          vnum_n = '0;
          if (num_vec == '0) begin
            state_n = S_DONE;
          end else begin
            state_n   = S_APPLY;
            // The first vector needs one extra APPLY cycle because vec_out
            // is only loaded on the edge after Start.
            cnt_n     = CW'(SETTLE);
            run_len_n = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
          end
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_n = S_IDLE;
          vec_n   = '0;
          valid_n = 1'b0;
        end else begin
          vec_n   = tbl_vec[cur_idx];
          valid_n = 1'b1;
          if (cnt == '0) state_n = S_CHECK;
          else           cnt_n   = cnt - 1'b1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_n = S_IDLE;
          vec_n   = '0;
          valid_n = 1'b0;
        end else begin
          if (mism) begin
            if (errors != '1) err_n = errors + 1'b1;
            if (errors == '0) ferr_n = cur_idx;
          end
          vnum_n = nxt;
          if (nxt == run_len) begin
            state_n = S_DONE;
            vec_n   = '0;
            valid_n = 1'b0;
          end else begin
            // The next vector goes on the bus on this same edge.
            state_n = S_APPLY;
            cnt_n   = CW'(SETTLE - 1);
            vec_n   = tbl_vec[nxt_idx];
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      run_len    <= '0;
      vec_out    <= '0;
      vec_valid  <= 1'b0;
      vector_num <= '0;
      errors     <= '0;
      first_err  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      run_len    <= run_len_n;
      vec_out    <= vec_n;
      vec_valid  <= valid_n;
      vector_num <= vnum_n;
      errors     <= err_n;
      first_err  <= ferr_n;
    end
  end

endmodule

// File: tb/tb_vec_sequencer.sv
// Directed testbench for vec_sequencer (default parameters, SETTLE = 1).
// The datapath is modelled as resp_in = low byte of vec_out, so an entry
// passes when its expected value equals the low byte of its control word.
module tb_vec_sequencer;

  localparam int VEC_W  = 42;
  localparam int RESP_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [VEC_W-1:0]  load_vec;
  logic [RESP_W-1:0] load_exp;
  logic [RESP_W-1:0] load_mask;
  logic [AW:0]       num_vec;
  logic              start;
  logic              abort;
  logic [RESP_W-1:0] resp_in;
  logic [VEC_W-1:0]  vec_out;
  logic              vec_valid;
  logic              busy;
  logic              done;
  logic [AW:0]       vector_num;
  logic [AW:0]       errors;
  logic [AW-1:0]     first_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign resp_in = vec_out[RESP_W-1:0];

  vec_sequencer #(
    .VEC_W(VEC_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .SETTLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_vec(load_vec),
    .load_exp(load_exp),
`ifdef VSEQ_MASK_EN
    .load_mask(load_mask),
`endif
    .num_vec(num_vec), .start(start), .abort(abort), .resp_in(resp_in),
    .vec_out(vec_out), .vec_valid(vec_valid), .busy(busy), .done(done),
    .vector_num(vector_num), .errors(errors), .first_err(first_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] mkvec(input int i, input logic [7:0] low);
    logic [33:0] hi;
    hi = 34'h1_2345_0000 + 34'(i * 7);
    return {hi, low};
  endfunction

  task automatic load(input int a, input logic [VEC_W-1:0] v, input logic [7:0] e,
                      input logic [7:0] m);
    load_en = 1'b1; load_addr = AW'(a); load_vec = v; load_exp = e; load_mask = m;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic kick(input int n);
    num_vec = (AW+1)'(n); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_vec = '0; load_exp = '0;
    load_mask = 8'hFF; num_vec = '0; start = 1'b0; abort = 1'b0;
    tick(3);
    chk("rst_vec_out", vec_out, 0);
    chk("rst_valid", vec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vnum", vector_num, 0);
    chk("rst_errors", errors, 0);
    chk("rst_first_err", first_err, 0);
    rst_n = 1'b1;
    tick(1);

    // Matching table entries 0..3 (exp 11,22,33,44).
    for (int i = 0; i < 4; i++) load(i, mkvec(i, 8'(8'h11 * (i + 1))), 8'(8'h11 * (i + 1)), 8'hFF);

    // Reset mid-run at vector 2.
    kick(4);
    tick(5);
    chk("mid_vnum_before_rst", vector_num, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec_out", vec_out, 0);
    chk("mid_rst_valid", vec_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_vnum", vector_num, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Pass run: 4 vectors, done 9 edges after start.
    kick(4);
    chk("pass_busy_n", busy, 1);
    chk("pass_valid_n", vec_valid, 0);
    tick(1);
    chk("pass_valid_n1", vec_valid, 1);
    chk("pass_vec0", vec_out, mkvec(0, 8'h11));
    tick(4);
    chk("pass_vec2", vec_out, mkvec(2, 8'h33));
    tick(3);
    chk("pass_done_n8", done, 0);
    tick(1);
    chk("pass_done_n9", done, 1);
    chk("pass_busy_end", busy, 0);
    chk("pass_errors", errors, 0);
    chk("pass_vnum", vector_num, 4);
    chk("pass_valid_end", vec_valid, 0);
    chk("pass_vec_end", vec_out, 0);

    // Fail run: entries 1 and 3 expect 55 but the datapath returns AA.
    load(1, mkvec(1, 8'hAA), 8'h55, 8'hFF);
    load(3, mkvec(3, 8'hAA), 8'h55, 8'hFF);
    kick(4);
    tick(9);
    chk("fail_done", done, 1);
    chk("fail_errors", errors, 2);
    chk("fail_first_err", first_err, 1);
    chk("fail_vnum", vector_num, 4);

    // Num_Vec = 0: done on the next edge, errors cleared.
    kick(0);
    chk("zero_done", done, 1);
    chk("zero_errors", errors, 0);
    chk("zero_busy", busy, 0);
    chk("zero_vnum", vector_num, 0);

    // Num_Vec = DEPTH+5 clamps to DEPTH vectors (done at 16*2+1 = 33 edges).
    for (int i = 0; i < DEPTH; i++) load(i, mkvec(i, 8'(i * 3 + 1)), 8'(i * 3 + 1), 8'hFF);
    kick(DEPTH + 5);
    tick(32);
    chk("clamp_done_n32", done, 0);
    tick(1);
    chk("clamp_done_n33", done, 1);
    chk("clamp_vnum", vector_num, DEPTH);
    chk("clamp_errors", errors, 0);

    // Abort during vector 2; Start and Load_En while busy are ignored.
    kick(4);
    tick(1);
    start = 1'b1; num_vec = 5'd1;
    load_en = 1'b1; load_addr = 4'd2; load_vec = mkvec(99, 8'h07); load_exp = 8'h07;
    tick(1);
    start = 1'b0; load_en = 1'b0;
    tick(3);
    chk("abort_vnum_before", vector_num, 2);
    chk("busy_load_ignored", vec_out, mkvec(2, 8'h07));
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", vec_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_vnum", vector_num, 2);
    chk("abort_errors", errors, 0);

    // Start together with Abort in IDLE: nothing starts.
    abort = 1'b1;
    kick(4);
    abort = 1'b0;
    chk("startabort_busy", busy, 0);
    chk("startabort_vnum", vector_num, 2);

    // Load and Start on the same edge: the run sees the new entry.
    load_en = 1'b1; load_addr = 4'd0; load_vec = mkvec(42, 8'h9C); load_exp = 8'h9C;
    kick(1);
    load_en = 1'b0;
    tick(1);
    chk("loadstart_vec", vec_out, mkvec(42, 8'h9C));
    tick(2);
    chk("loadstart_done", done, 1);
    chk("loadstart_errors", errors, 0);

`ifdef VSEQ_MASK_EN
    load(0, mkvec(5, 8'hF7), 8'hF0, 8'hF0);
    kick(1);
    tick(3);
    chk("mask_f0_errors", errors, 0);
    load(0, mkvec(5, 8'hF7), 8'hF0, 8'hFF);
    kick(1);
    tick(3);
    chk("mask_ff_errors", errors, 1);
    chk("mask_ff_first_err", first_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
